// File: rtl/capture_core_pkg.sv
// Shared encodings for the input-capture core and its edge-detect front end.
package capture_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse on the selected edge type.
module sync_edge_detect
    import capture_core_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in,
    input  logic [1:0] i_edge_sel,
    output logic       o_edge_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Reserved select code falls back to rising-edge detection.
    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        case (i_edge_sel)
            EDGE_FALL: o_edge_c = ~level & prev_q;
            EDGE_BOTH: o_edge_c = level ^ prev_q;
            default:   o_edge_c = level & ~prev_q;
        endcase
    end

endmodule

// File: rtl/capture_core.sv
// Input-capture core: measures cycles between qualifying edges and latches the period with a sticky interrupt.
module capture_core
    import capture_core_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_capture_en,
    input  logic             i_cont,
    input  logic [1:0]       i_edge_sel,
    input  logic             i_irq_clear,
    input  logic             i_capture_in,
    output logic [WIDTH-1:0] o_capture,
    output logic             o_irq,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] capture_d;
    logic             irq_d, ovf_d, busy_d;
    logic             edge_c;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_in      (i_capture_in),
        .i_edge_sel(i_edge_sel),
        .o_edge_c  (edge_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            o_capture  <= '0;
            o_irq      <= 1'b0;
            o_overflow <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_capture  <= capture_d;
            o_irq      <= irq_d;
            o_overflow <= ovf_d;
            o_busy     <= busy_d;
        end
    end

    // Next-state, counter and result logic; a capture overrides a same-cycle clear.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_d = o_capture;
        irq_d     = o_irq;
        ovf_d     = o_overflow;

        if (i_irq_clear) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                irq_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = ST_ARMED;
            end
            ST_ARMED: begin
                cnt_d = '0;
                if (edge_c) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_c) begin
                    capture_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + WIDTH'(1);
                    irq_d     = 1'b1;
                    if (cnt_q >= CNT_MAX - WIDTH'(1)) begin
                        ovf_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = i_cont ? ST_MEASURE : ST_DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (i_irq_clear) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!i_capture_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            irq_d   = 1'b0;
            ovf_d   = 1'b0;
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_MEASURE);
    end

endmodule

// File: tb/tb_capture_core.sv
// Randomized scoreboard bench for capture_core against a period-level reference model.
module tb_capture_core;

    localparam int unsigned WIDTH = 16;
    localparam int          LAT   = 3;

    logic             clk = 1'b0;
    logic             rst, en, cont, clr, cap_in;
    logic [1:0]       sel;
    logic [WIDTH-1:0] o_capture;
    logic             o_irq, o_overflow, o_busy;

    always #5 clk = ~clk;

    capture_core #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_capture_en(en),
        .i_cont      (cont),
        .i_edge_sel  (sel),
        .i_irq_clear (clr),
        .i_capture_in(cap_in),
        .o_capture   (o_capture),
        .o_irq       (o_irq),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] cap;
        logic             ovf;
        int               at;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: tracks only whether we are off, waiting for a start edge,
    // timing a period, or holding a one-shot result, and the time of the last edge.
    localparam int M_OFF = 0, M_WAIT = 1, M_RUN = 2, M_HOLD = 3;
    int         m_mode = M_OFF;
    int         m_last = 0;
    logic [1:0] m_sel  = 2'd0;
    bit         m_cont = 1'b0;
    bit         m_en   = 1'b0;

    function automatic bit qualifies(input logic lvl);
        if (m_sel == 2'd2) return 1'b1;
        if (m_sel == 2'd1) return lvl == 1'b0;
        return lvl == 1'b1;
    endfunction

    task automatic tog(input logic lvl);
        exp_t e;
        int   n;
        cap_in = lvl;
        if (!qualifies(lvl)) return;
        if (m_mode == M_WAIT) begin
            m_mode = M_RUN;
            m_last = cyc;
        end else if (m_mode == M_RUN) begin
            n     = cyc - m_last;
            e.cap = (n >= 65535) ? 16'hFFFF : n[WIDTH-1:0];
            e.ovf = (n >= 65535);
            e.at  = cyc + LAT;
            sb.push_back(e);
            m_last = cyc;
            if (!m_cont) m_mode = M_HOLD;
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_en(input logic v);
        en     = v;
        m_en   = v;
        m_mode = v ? M_WAIT : M_OFF;
    endtask

    task automatic set_mode(input logic [1:0] s, input logic c);
        sel    = s;
        m_sel  = s;
        cont   = c;
        m_cont = c;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        if (m_mode == M_HOLD) m_mode = M_WAIT;
        wait_n(1);
        clr = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        wait_n(1);
        rst    = 1'b0;
        m_mode = m_en ? M_WAIT : M_OFF;
    endtask

    // Monitor: a new result is any change of o_capture or a rising o_irq.
    logic [WIDTH-1:0] prev_cap = '0;
    logic             prev_irq = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (o_capture !== prev_cap || (o_irq === 1'b1 && prev_irq !== 1'b1)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_capture: got %0h expected none (cycle %0d)", o_capture, cyc);
                end else begin
                    e = sb.pop_front();
                    check("capture_value", 32'(o_capture), 32'(e.cap));
                    check("capture_overflow", 32'(o_overflow), 32'(e.ovf));
                    check("capture_irq", 32'(o_irq), 32'd1);
                    check("capture_latency", 32'(cyc), 32'(e.at));
                end
            end
        end
        prev_cap = o_capture;
        prev_irq = o_irq;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         p, lastp, w;
        logic       rest, lvl;
        logic [1:0] rs;

        rst = 1'b1; en = 1'b0; cont = 1'b0; clr = 1'b0; cap_in = 1'b0; sel = 2'd0;
        wait_n(3);
        check("reset_capture", 32'(o_capture), 32'd0);
        check("reset_irq", 32'(o_irq), 32'd0);
        check("reset_overflow", 32'(o_overflow), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;

        // Continuous rising-edge capture.
        set_mode(2'd0, 1'b1);
        set_en(1'b1);
        wait_n(5);
        check("armed_busy", 32'(o_busy), 32'd1);
        tog(1'b1); wait_n(3); tog(1'b0); wait_n(97); tog(1'b1);
        wait_n(3); tog(1'b0); wait_n(247); tog(1'b1);
        wait_n(6);
        check("cont_irq_sticky", 32'(o_irq), 32'd1);
        check("cont_capture_250", 32'(o_capture), 32'd250);

        // One-shot falling-edge capture.
        set_en(1'b0); wait_n(3);
        set_mode(2'd1, 1'b0);
        tog(1'b1); wait_n(5);
        set_en(1'b1); wait_n(5);
        tog(1'b0); wait_n(3); tog(1'b1); wait_n(37); tog(1'b0);
        wait_n(5);
        check("oneshot_done_busy", 32'(o_busy), 32'd0);
        tog(1'b1); wait_n(5); tog(1'b0);
        wait_n(6);
        check("oneshot_hold_capture", 32'(o_capture), 32'd40);
        check("oneshot_hold_irq", 32'(o_irq), 32'd1);
        pulse_clear();
        wait_n(3);
        check("clear_irq", 32'(o_irq), 32'd0);
        check("clear_rearm_busy", 32'(o_busy), 32'd1);
        tog(1'b1); wait_n(3); tog(1'b0); wait_n(3); tog(1'b1); wait_n(4); tog(1'b0);
        wait_n(6);

        // Both-edge mode.
        set_en(1'b0); wait_n(3);
        set_mode(2'd2, 1'b1);
        tog(1'b0); wait_n(5);
        set_en(1'b1); wait_n(5);
        tog(1'b1); wait_n(30); tog(1'b0); wait_n(50); tog(1'b1);
        wait_n(6);

        // Overflow in one-shot rising mode.
        set_en(1'b0); wait_n(3);
        set_mode(2'd0, 1'b0);
        tog(1'b0); wait_n(5);
        set_en(1'b1); wait_n(5);
        tog(1'b1); wait_n(3); tog(1'b0); wait_n(69997); tog(1'b1);
        wait_n(6);
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_capture", 32'(o_capture), 32'hFFFF);
        pulse_clear();
        wait_n(3);
        check("ovf_clear_irq", 32'(o_irq), 32'd0);
        check("ovf_clear_flag", 32'(o_overflow), 32'd0);
        check("ovf_keep_capture", 32'(o_capture), 32'hFFFF);

        // Clear coinciding with the capture cycle, then enable dropped mid-measure.
        set_mode(2'd0, 1'b1);
        tog(1'b0); wait_n(3); tog(1'b1); wait_n(3); tog(1'b0); wait_n(57); tog(1'b1);
        wait_n(2);
        clr = 1'b1;
        wait_n(1);
        clr = 1'b0;
        check("clear_vs_capture_irq", 32'(o_irq), 32'd1);
        wait_n(5);
        set_en(1'b0);
        wait_n(1);
        check("disable_busy", 32'(o_busy), 32'd0);
        check("disable_irq", 32'(o_irq), 32'd0);
        wait_n(3);
        set_en(1'b1); wait_n(5);
        tog(1'b0); wait_n(3); tog(1'b1); wait_n(3); tog(1'b0); wait_n(17); tog(1'b1);
        wait_n(6);

        // Reset in the middle of a period.
        tog(1'b0); wait_n(4);
        tog(1'b1); wait_n(3); tog(1'b0); wait_n(17);
        pulse_reset();
        check("midrst_capture", 32'(o_capture), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        check("midrst_overflow", 32'(o_overflow), 32'd0);
        check("midrst_busy", 32'(o_busy), 32'd0);
        wait_n(79); tog(1'b1);
        wait_n(6);
        check("midrst_arm_capture", 32'(o_capture), 32'd0);
        check("midrst_arm_irq", 32'(o_irq), 32'd0);
        tog(1'b0); wait_n(39); tog(1'b1);
        wait_n(6);

        // Randomized continuous-mode batches with random edge selection.
        for (int b = 0; b < 3; b++) begin
            set_en(1'b0); wait_n(3);
            rs = 2'($urandom_range(0, 3));
            set_mode(rs, 1'b1);
            rest = (rs == 2'd1);
            tog(rest); wait_n(5);
            set_en(1'b1); wait_n(5);
            lvl = ~rest;
            tog(lvl);
            lastp = 0;
            for (int k = 0; k < 8; k++) begin
                do p = int'($urandom_range(4, 300)); while (p == lastp);
                lastp = p;
                if (rs == 2'd2) begin
                    wait_n(p);
                    lvl = ~lvl;
                    tog(lvl);
                end else begin
                    w = int'($urandom_range(1, p - 1));
                    wait_n(w);  tog(rest);
                    wait_n(p - w); tog(~rest);
                end
            end
            wait_n(6);
        end

        wait_n(10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_core.md
Name: capture_core

Overview:
- Input-capture counterpart to the periodic timer core: it measures elapsed clock cycles between qualifying edges of an external signal instead of generating events from a programmed period.
- Latches each measured period and raises an interrupt.
- Supports continuous or one-shot capture, with overflow detection.
- Sits beside the timer core behind the same register block and divided clock.

Parameters:
- WIDTH, 16, width of the internal counter and of o_capture.
- SYNC_STAGES, 2, flip-flop stages on i_capture_in (minimum 2).

Ports:
- i_clk  input  1  divided clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_capture_en  input  1  block enable; low forces IDLE.
- i_cont  input  1  1 = continuous capture, 0 = one-shot.
- i_edge_sel  input  2  00 rising, 01 falling, 10 both, 11 reserved (treated as rising).
- i_irq_clear  input  1  active-high, single-cycle clear of o_irq and o_overflow.
- i_capture_in  input  1  asynchronous external signal.
- o_capture  output  WIDTH  last measured period, in i_clk cycles.
- o_irq  output  1  capture-complete interrupt, sticky.
- o_overflow  output  1  sticky; set when a period saturated the counter.
- o_busy  output  1  high in ARMED or MEASURE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: o_capture=0, o_irq=0, o_overflow=0, o_busy=0, counter=0, state=IDLE, synchronizer flops=0, previous-level flop=0.
- Synchronizer and edge detect:
  - i_capture_in passes through SYNC_STAGES flops; a registered copy of the synchronized level feeds edge detection.
  - A qualifying edge is registered in o_capture/o_irq SYNC_STAGES+1 clock edges after i_capture_in is first sampled at its new level. That is 3 cycles at the default.
- State machine (2-bit state):
  - IDLE -> ARMED when i_capture_en=1. Counter held at 0.
  - ARMED: wait for the first qualifying edge. On that edge: counter <= 0, go to MEASURE. No capture on this edge.
  - MEASURE: counter increments by 1 each cycle and saturates at all-ones (no wrap). On a qualifying edge:
    - o_capture <= counter+1, saturated at all-ones.
    - o_irq <= 1.
    - o_overflow <= 1 if the counter was saturated.
    - counter <= 0.
    - Next state: stay in MEASURE if i_cont=1, else go to DONE.
  - DONE: counter frozen and outputs held. Go to ARMED on the cycle i_irq_clear=1.
  - Any state -> IDLE whenever i_capture_en=0. In IDLE, o_irq and o_overflow clear; o_capture retains its value.
- Result semantics: two qualifying edges N synchronized cycles apart give o_capture=N, for 1 <= N < 2^WIDTH-1. Any N >= 2^WIDTH-1 gives all-ones and sets o_overflow.
- Edge and clear in the same cycle: capture wins, so o_irq=1 after that edge.
- Continuous mode: a new edge while o_irq=1 overwrites o_capture and o_irq stays 1.
- i_rst asserted mid-measurement: all state returns to reset values on that edge; the partial period is discarded.
- Mid-measurement changes:
  - i_edge_sel change takes effect on the next cycle's edge detection.
  - i_cont change takes effect at the next capture.
- o_busy = (state==ARMED) or (state==MEASURE), registered.

Decomposition:
- Shared package constants:
  - state encodings IDLE=0, ARMED=1, MEASURE=2, DONE=3;
  - edge-select codes EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
- One sub-module, sync_edge_detect: parameterised synchronizer plus edge-select logic, emitting a single-cycle edge pulse. It is reusable for future external-trigger inputs of the timer core.

Test Plan:
- Continuous rising-edge capture: reset, en=1, cont=1, sel=00, rising edges 100 cycles apart -> o_irq rises 3 cycles after the 2nd edge, o_capture=100; a 3rd edge 250 cycles later -> o_capture=250, o_irq stays 1.
- One-shot falling-edge capture: cont=0, sel=01, falling edges 40 cycles apart -> o_capture=40, state DONE; a further edge 10 cycles later leaves o_capture unchanged; i_irq_clear pulse -> o_irq=0, ARMED; the next edge pair 7 cycles apart -> o_capture=7.
- Both-edge mode: sel=10, high for 30 cycles then low for 50 -> o_capture=30, then 50.
- Overflow: edges 70000 cycles apart, WIDTH=16 -> o_capture=16'hFFFF, o_overflow=1; clear pulse -> both flags 0, o_capture keeps 16'hFFFF.
- Simultaneous clear and edge: i_irq_clear asserted on the exact capture cycle -> o_irq=1. Separately, en dropped mid-MEASURE -> next cycle o_busy=0, o_irq=0, and re-enable requires a fresh arming edge.
- Reset mid-measurement: assert i_rst 20 cycles into a 100-cycle period -> on the next edge all outputs 0, and the subsequent edge is treated as the arming edge.
